// File: rtl/pulse_meter_if.sv
// Bus for pulse_meter: the line under measurement plus the published
// measurement, status and FSM debug state.
interface pulse_meter_if #(
  parameter int CW = 24,
  parameter int NW = 16
);
  // valid is a one-cycle strobe with no ready/backpressure: width and period
  // change only in the cycle valid is high, and a consumer must capture them
  // then or read the held values later.
  logic          pulse_in;
  logic [CW-1:0] width;
  logic [CW-1:0] period;
  logic          valid;
  logic          timeout;
  logic [NW-1:0] pulse_cnt;
  logic [1:0]    state_dbg;

  modport master (
    output pulse_in,
    input  width, period, valid, timeout, pulse_cnt, state_dbg
  );

  modport slave (
    input  pulse_in,
    output width, period, valid, timeout, pulse_cnt, state_dbg
  );
endinterface

// File: rtl/pulse_meter.sv
// Measures high width and rise-to-rise period of an asynchronous pulse line
// in clk cycles, strobes each complete measurement and flags stalled lines.
module pulse_meter #(
  parameter int CW = 24,
  parameter int NW = 16
) (
  input  logic         clk,
  input  logic         rst,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
  localparam logic [NW-1:0] N_ONE = {{(NW-1){1'b0}}, 1'b1};

  state_t        state, state_nx;
  logic          s1, s2, s3;
  logic          rise, fall, sat;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [CW-1:0] pcnt, pcnt_nx;
  logic [CW-1:0] held_w, held_w_nx;
  logic [CW-1:0] width_q, width_nx;
  logic [CW-1:0] period_q, period_nx;
  logic          valid_q, valid_nx;
  logic          timeout_q, timeout_nx;
  logic [NW-1:0] cnt_q, cnt_nx;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  // wcnt never exceeds pcnt, so pcnt alone decides saturation.
  assign sat  = (state != IDLE) && (pcnt == C_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    state_nx   = state;
    wcnt_nx    = wcnt;
    pcnt_nx    = pcnt;
    held_w_nx  = held_w;
    width_nx   = width_q;
    period_nx  = period_q;
    valid_nx   = 1'b0;
    timeout_nx = timeout_q;
    cnt_nx     = cnt_q;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HIGH;
          wcnt_nx  = C_ONE;
          pcnt_nx  = C_ONE;
        end
      end
      HIGH: begin
        if (sat) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
          wcnt_nx    = '0;
          pcnt_nx    = '0;
        end else begin
          wcnt_nx = wcnt + C_ONE;
          pcnt_nx = pcnt + C_ONE;
          if (fall) begin
            held_w_nx = wcnt;
            state_nx  = LOW;
          end
        end
      end
      LOW: begin
        // Saturation wins over a coincident rise; that rise starts nothing.
        if (sat) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
          wcnt_nx    = '0;
          pcnt_nx    = '0;
        end else if (rise) begin
          width_nx   = held_w;
          period_nx  = pcnt;
          valid_nx   = 1'b1;
          cnt_nx     = cnt_q + N_ONE;
          timeout_nx = 1'b0;
          state_nx   = HIGH;
          wcnt_nx    = C_ONE;
          pcnt_nx    = C_ONE;
        end else begin
          pcnt_nx = pcnt + C_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        wcnt_nx  = '0;
        pcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      pcnt      <= '0;
      held_w    <= '0;
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      pcnt      <= pcnt_nx;
      held_w    <= held_w_nx;
      width_q   <= width_nx;
      period_q  <= period_nx;
      valid_q   <= valid_nx;
      timeout_q <= timeout_nx;
      cnt_q     <= cnt_nx;
    end
  end

  assign bus.width     = width_q;
  assign bus.period    = period_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.pulse_cnt = cnt_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: table-driven pulse trains, hand-written corner
// sequences and random trains checked against a timestamp-level model.
module tb_pulse_meter;
  localparam int CW   = 8;
  localparam int NW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_meter_if #(.CW(CW), .NW(NW)) bus ();
  pulse_meter #(.CW(CW), .NW(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic          timeout;
    logic [NW-1:0] cnt;
  } snap_t;
  localparam int SW = $bits(snap_t);

  typedef struct {
    int hi;
    int lo;
    int reps;
    int ew;
    int ep;
  } vec_t;

  logic [SW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Model: measurement defined by rise/fall timestamps of the sampled line.
  snap_t m;
  bit    m_prev;
  bit    have_start, seen_fall;
  int    n, r_idx, f_idx;

  int valids_seen;
  int last_w, last_p;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  task automatic model_step(input bit v);
    bit rise, fall;
    rise = v & ~m_prev;
    fall = ~v & m_prev;
    m.valid = 1'b0;
    if (have_start && (n - r_idx) >= MAXC) begin
      m.timeout  = 1'b1;
      have_start = 1'b0;
    end else if (rise) begin
      if (have_start && seen_fall) begin
        m.valid   = 1'b1;
        m.width   = CW'(f_idx - r_idx);
        m.period  = CW'(n - r_idx);
        m.cnt     = NW'(m.cnt + 1);
        m.timeout = 1'b0;
      end
      have_start = 1'b1;
      seen_fall  = 1'b0;
      r_idx      = n;
    end else if (fall && have_start) begin
      seen_fall = 1'b1;
      f_idx     = n;
    end
    m_prev = v;
    n++;
    exp_q.push_back(m);
  endtask

  task automatic check_outputs();
    snap_t e, a;
    a.valid   = bus.valid;
    a.width   = bus.width;
    a.period  = bus.period;
    a.timeout = bus.timeout;
    a.cnt     = bus.pulse_cnt;
    if (bus.valid) begin
      valids_seen++;
      last_w = int'(bus.width);
      last_p = int'(bus.period);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL model_queue_empty at n=%0d", n);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL cycle n=%0d actual v=%0b w=%0d p=%0d t=%0b c=%0d expected v=%0b w=%0d p=%0d t=%0b c=%0d",
                 n, a.valid, a.width, a.period, a.timeout, a.cnt,
                 e.valid, e.width, e.period, e.timeout, e.cnt);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v);
    check_outputs();
    bus.pulse_in = v;
    model_step(v);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0);
  endtask

  task automatic train(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      repeat (hi) cycle(1'b1);
      repeat (lo) cycle(1'b0);
    end
  endtask

  task automatic do_reset(input bit v, input int ncyc);
    rst = 1'b1;
    bus.pulse_in = v;
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    m          = '0;
    m_prev     = 1'b0;
    have_start = 1'b0;
    seen_fall  = 1'b0;
    n          = 0;
    r_idx      = 0;
    f_idx      = 0;
    valids_seen = 0;
    last_w     = 0;
    last_p     = 0;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(SW'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_width"},   int'(bus.width), 0);
    chk({tag, "_period"},  int'(bus.period), 0);
    chk({tag, "_valid"},   int'(bus.valid), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_cnt"},     int'(bus.pulse_cnt), 0);
    chk({tag, "_state"},   int'(bus.state_dbg), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4, 6, 4, 4, 10};
    tbl[1] = '{1, 1, 6, 1, 2};
    tbl[2] = '{3, 5, 3, 3, 8};
    tbl[3] = '{127, 127, 2, 127, 254};
    tbl[4] = '{1, 253, 2, 1, 254};
    tbl[5] = '{200, 20, 2, 200, 220};
    tbl[6] = '{5, 1, 3, 5, 6};

    bus.pulse_in = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 2);
    chk_zero_outputs("reset");

    for (int i = 0; i < 7; i++) begin
      do_reset(1'b0, 2);
      train(tbl[i].hi, tbl[i].lo, tbl[i].reps);
      cycle(1'b1);
      idle(4);
      chk($sformatf("tbl%0d_width", i), last_w, tbl[i].ew);
      chk($sformatf("tbl%0d_period", i), last_p, tbl[i].ep);
      chk($sformatf("tbl%0d_valids", i), valids_seen, tbl[i].reps);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.pulse_cnt), tbl[i].reps % 16);
      chk($sformatf("tbl%0d_timeout", i), int'(bus.timeout), 0);
    end

    // Stuck high from the first rise, then a clean 3/5 train.
    do_reset(1'b0, 2);
    idle(3);
    repeat (300) cycle(1'b1);
    idle(5);
    chk("stuck_timeout", int'(bus.timeout), 1);
    chk("stuck_valids", valids_seen, 0);
    train(3, 5, 2);
    cycle(1'b1);
    idle(4);
    chk("recover_width", last_w, 3);
    chk("recover_period", last_p, 8);
    chk("recover_timeout", int'(bus.timeout), 0);
    chk("recover_valids", valids_seen, 2);

    // Period of exactly 2^CW-1: saturation beats the coincident rise.
    do_reset(1'b0, 2);
    train(100, 155, 2);
    cycle(1'b1);
    idle(4);
    chk("coincide_timeout", int'(bus.timeout), 1);
    chk("coincide_valids", valids_seen, 0);

    // Reset while the FSM sits in LOW.
    do_reset(1'b0, 2);
    train(4, 6, 2);
    repeat (4) cycle(1'b1);
    repeat (4) cycle(1'b0);
    chk("pre_midrst_state", int'(bus.state_dbg), 2);
    do_reset(1'b0, 1);
    chk_zero_outputs("midrst");
    train(4, 6, 1);
    chk("midrst_one_rise_valids", valids_seen, 0);
    cycle(1'b1);
    idle(4);
    chk("midrst_valids", valids_seen, 1);
    chk("midrst_width", last_w, 4);
    chk("midrst_period", last_p, 10);

    // Line already high while reset is released.
    do_reset(1'b1, 2);
    repeat (3) cycle(1'b1);
    repeat (6) cycle(1'b0);
    train(4, 6, 2);
    cycle(1'b1);
    idle(4);
    chk("prehigh_width", last_w, 4);
    chk("prehigh_period", last_p, 10);

    // Pulse counter wraps modulo 2^NW.
    do_reset(1'b0, 2);
    train(1, 1, 18);
    cycle(1'b1);
    idle(4);
    chk("wrap_valids", valids_seen, 18);
    chk("wrap_cnt", int'(bus.pulse_cnt), 2);

    // Random trains, occasionally long enough to saturate.
    do_reset(1'b0, 2);
    for (int i = 0; i < 60; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(240, 300);
      if ($urandom_range(0, 14) == 0) hi = $urandom_range(240, 300);
      train(hi, lo, 1);
    end
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side counterpart to the LED pulse generator.
- Samples an asynchronous pulse line on CLK and measures the high width and rising-edge-to-rising-edge period of every complete pulse, in CLK cycles.
- Publishes each measurement with a one-cycle strobe.
- Flags lines that stall (stuck high or stuck low) and counts good pulses.
- Used in self-check benches and on board to confirm pulser timing.

Parameters:
- CW, 24, width of the width/period counters and result outputs.
- NW, 16, width of the good-pulse counter.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- PULSE_IN  input  1  asynchronous pulse line under measurement
- WIDTH  output  CW  high time of the last complete pulse, in cycles
- PERIOD  output  CW  rise-to-rise time of the last complete pulse, in cycles
- VALID  output  1  one-cycle strobe; WIDTH/PERIOD updated this cycle
- TIMEOUT  output  1  sticky; a counter saturated, so the measurement was discarded
- PULSE_CNT  output  NW  number of VALID strobes since reset; wraps

Behaviour:
- Clock and reset: single clock domain CLK. Reset is synchronous and active-high, sampled only on the CLK rising edge.
- Reset values: WIDTH=0, PERIOD=0, VALID=0, TIMEOUT=0, PULSE_CNT=0. Synchronizer flops s1, s2, s3 reset to 0. State is IDLE and both counters are 0.
- Reset asserted mid-measurement abandons the measurement. No VALID is issued.
- Input path: PULSE_IN -> s1 -> s2 -> s3.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - Edge-detect latency from a PULSE_IN change to rise/fall is 2 to 3 cycles. Width and period values are unaffected because both edges see the same delay.
- State machine:
  - IDLE: wait for rise. On rise: go to HIGH, wcnt=1, pcnt=1. Any fall seen in IDLE is ignored, so the first, partial pulse after reset or timeout is never reported.
  - HIGH: wcnt+=1 and pcnt+=1 each cycle. On fall: latch wcnt into held_w, go to LOW, pcnt+=1.
  - LOW: pcnt+=1 each cycle. On rise, in a single cycle:
    - WIDTH<=held_w
    - PERIOD<=pcnt
    - VALID<=1
    - PULSE_CNT<=PULSE_CNT+1 (wraps modulo 2^NW)
    - TIMEOUT<=0
    - go to HIGH, with wcnt=1 and pcnt=1 (back-to-back measurement, no lost pulse)
- Counter values: WIDTH equals the number of cycles s2 was high. PERIOD equals the number of cycles between successive rise events. Example: a pulse 4 cycles high with a 10-cycle period gives WIDTH=4, PERIOD=10.
- VALID timing: registered; high exactly one cycle, in the cycle after the rise that completes a period. WIDTH/PERIOD change only on that edge and hold otherwise.
- Saturation:
  - If pcnt would exceed 2^CW-1 in HIGH or LOW: set TIMEOUT=1, go to IDLE, hold WIDTH/PERIOD, no VALID.
  - A rise arriving in the same cycle as saturation: the timeout takes priority, and that rise is not used as a period start.
  - wcnt <= pcnt always, so pcnt alone governs saturation.
- Minimum measurable pulse: 1 cycle high and 1 cycle low (PERIOD=2). Glitches shorter than one CLK period may be missed; this is accepted.
- TIMEOUT is sticky and clears only on RST or on the next VALID.

Test Plan:
- RST for 2 cycles, then a square wave 4 cycles high / 6 cycles low -> first VALID after the 2nd rising edge with WIDTH=4, PERIOD=10; then VALID every 10 cycles; PULSE_CNT increments 1, 2, 3.
- Bench LED stimulus with period 2^20 cycles (50% duty), CW=24 -> WIDTH=524288, PERIOD=1048576, TIMEOUT=0.
- PULSE_IN held high from the first rise with CW=8 -> TIMEOUT=1 after 255 cycles in HIGH, no VALID. A following 3-high/5-low train -> VALID with WIDTH=3, PERIOD=8 and TIMEOUT cleared.
- Alternating 1-high/1-low input -> WIDTH=1, PERIOD=2, VALID every 2 cycles.
- RST pulsed during LOW of a 4/6 train -> all outputs 0 next cycle; the first post-reset VALID appears only after two full rises.
- PULSE_IN already high when RST deasserts -> the partial pulse is ignored; the first reported WIDTH/PERIOD match the programmed values exactly.
